// File: rtl/ballot_sequencer.sv
// Ballot front-end: arms one ballot per voter, arbitrates four candidate buttons,
// emits one vote-increment pulse per accepted ballot, then enforces a lockout.
// Optional ballot expiry timer is enabled by defining BALLOT_TIMEOUT_EN.
module ballot_sequencer #(
    parameter int LOCKOUT_CYCLES = 10,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int COUNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic               arm,
    input  logic               candidate1_button_press,
    input  logic               candidate2_button_press,
    input  logic               candidate3_button_press,
    input  logic               candidate4_button_press,
    output logic               ready,
    output logic               busy,
    output logic               valid_vote_casted,
    output logic [3:0]         candidate_inc,
    output logic               rejected,
    output logic               timeout,
    output logic [COUNT_W-1:0] ballot_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RELEASE,
        S_ARMED,
        S_CAST,
        S_LOCKOUT
    } state_t;

    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    state_t            state;
    logic [LOCK_W-1:0] lock_cnt;
    logic [3:0]        buttons;
    logic              any_press;
    logic              one_hot;
    logic              multi_press;
    logic              expire;

    assign buttons     = {candidate4_button_press, candidate3_button_press,
                          candidate2_button_press, candidate1_button_press};
    assign any_press   = (buttons != 4'b0000);
    assign one_hot     = any_press && ((buttons & (buttons - 4'd1)) == 4'b0000);
    assign multi_press = any_press && !one_hot;

`ifdef BALLOT_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] ballot_timer;

    // Held at zero in IDLE, so every fresh ballot starts from zero; a reject
    // back to WAIT_RELEASE keeps counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            ballot_timer <= '0;
        end else if (state == S_IDLE) begin
            ballot_timer <= '0;
        end else if (state == S_WAIT_RELEASE || state == S_ARMED) begin
            ballot_timer <= ballot_timer + 1'b1;
        end
    end

    assign expire = (ballot_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    // NOTE: all state and pulse registers use non-blocking assignments so every
    // branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            lock_cnt      <= '0;
            candidate_inc <= 4'b0000;
            rejected      <= 1'b0;
            timeout       <= 1'b0;
            ballot_count  <= '0;
        end else begin
            rejected      <= 1'b0;
            timeout       <= 1'b0;
            candidate_inc <= 4'b0000;

            case (state)
                S_IDLE: begin
                    if (arm && !mode) begin
                        state <= S_WAIT_RELEASE;
                    end
                end

                S_WAIT_RELEASE: begin
                    if (mode) begin
                        state <= S_IDLE;
                    end else if (expire) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else if (!any_press) begin
                        state <= S_ARMED;
                    end
                end

                // Same-cycle priority: mode abort, expiry, reject, accept.
                S_ARMED: begin
                    if (mode) begin
                        state <= S_IDLE;
                    end else if (expire) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else if (multi_press) begin
                        rejected <= 1'b1;
                        state    <= S_WAIT_RELEASE;
                    end else if (one_hot) begin
                        candidate_inc <= buttons;
                        state         <= S_CAST;
                    end
                end

                S_CAST: begin
                    if (ballot_count != {COUNT_W{1'b1}}) begin
                        ballot_count <= ballot_count + 1'b1;
                    end
                    lock_cnt <= '0;
                    state    <= S_LOCKOUT;
                end

                S_LOCKOUT: begin
                    if (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready             = (state == S_ARMED);
    assign busy              = (state != S_IDLE);
    assign valid_vote_casted = (state == S_CAST);

endmodule
